// File: rtl/cla_seq_adder.sv
// Sequential adder: one 4-bit carry-lookahead slice per cycle.
// Valid/ready on both sides; result held in DONE until taken.
module cla_seq_adder #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    base;

  logic [3:0] sa;
  logic [3:0] sb;
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] s;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       gg;
  logic       pp;
  logic       co;

  assign base = {idx, 2'b00};

  // Lookahead slice on the current nibble of the latched operands
  always_comb begin
    sa = a_q[base +: 4];
    sb = b_q[base +: 4];
    p  = sa ^ sb;
    g  = sa & sb;
    c1 = g[0] | (p[0] & c_q);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & c_q);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
    pp = &p;
    co = gg | (pp & c_q);
    s  = p ^ {c3, c2, c1, c_q};
  end

  // Control FSM, slice datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      c_q       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            c_q      <= cin;
            idx      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          sum[base +: 4] <= s;
          c_q            <= co;
          if (idx == LAST) begin
            cout      <= co;
            ovf       <= c3 ^ co;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=16).
// Checks latency, hold, mid-op reset and back-to-back throughput.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, check latency and result, hold, then release
  task automatic run_op(input string tag, input logic [15:0] va,
                        input logic [15:0] vb, input logic vc,
                        input logic [15:0] es, input logic ec,
                        input logic eo, input int hold);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~va;
    b = 16'hA5A5;
    cin = ~vc;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".in_ready_calc"}, 32'(in_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
    end
    tick();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_sum"}, 32'(sum), 32'(es));
      chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_sum"}, 32'(sum), 32'(es));
  endtask

  logic [15:0] ra[3];
  logic [15:0] rb[3];
  logic        rc[3];

  initial begin
    int acc;
    int res;
    int last;
    bit will_acc;
    logic [16:0] ref_v;
    logic        ref_o;

    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 16'h1111;
    b = 16'h2222;
    cin = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    run_op("v1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op("v2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("v3", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
    run_op("hold", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 5);
    run_op("neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);

    a = 16'h1111;
    b = 16'h2222;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.in_ready", 32'(in_ready), 32'd1);
    chk("mrst.sum", 32'(sum), 32'd0);
    run_op("post", 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, 0);

    for (int i = 0; i < 3; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);
    end
    acc = 0;
    res = 0;
    last = 0;
    a = ra[0];
    b = rb[0];
    cin = rc[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && res < 3; cyc++) begin
      if (out_valid) begin
        ref_v = {1'b0, ra[res]} + {1'b0, rb[res]} + 17'(rc[res]);
        ref_o = (ra[res][15] == rb[res][15]) && (ref_v[15] != ra[res][15]);
        chk("b2b.sum", 32'(sum), 32'(ref_v[15:0]));
        chk("b2b.cout", 32'(cout), 32'(ref_v[16]));
        chk("b2b.ovf", 32'(ovf), 32'(ref_o));
        res++;
      end
      will_acc = in_ready && acc < 3;
      tick();
      if (will_acc) begin
        if (acc > 0) chk("b2b.spacing", 32'(cyc + 1 - last), 32'd6);
        last = cyc + 1;
        acc++;
        if (acc < 3) begin
          a = ra[acc];
          b = rb[acc];
          cin = rc[acc];
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b.results", 32'(res), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits (multiple of 4, minimum 4).
REQ-002 The block SHALL have parameter NIB, default WIDTH/4, meaning number of 4-bit slices (derived; not overridden).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  operand set present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 The block SHALL have port b  input  WIDTH  operand B.
REQ-009 The block SHALL have port cin  input  1  carry into bit 0.
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-012 The block SHALL have port sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-013 The block SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 The block SHALL have port ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
REQ-015 The block SHALL have port busy  output  1  high in CALC state.

Function
REQ-016 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-018 A transfer SHALL occur on an edge with in_valid=1 and in_ready=1: the block latches a, b and cin, clears the slice index to 0, and moves IDLE->CALC.
REQ-019 In CALC, each cycle SHALL process slice i (bits 4i+3:4i) with p=a^b and g=a&b of that slice and carry-in c = the latched carry.
REQ-020 Intra-slice carries SHALL be lookahead: c1=g0|p0c; c2=g1|p1g0|p1p0c; c3=g2|p2g1|p2p1g0|p2p1p0c.
REQ-021 Slice sum bits SHALL be p^{c3,c2,c1,c}; slice carry-out SHALL be G|P·c, with G=g3|p3g2|p3p2g1|p3p2p1g0 and P=p3p2p1p0.
REQ-022 Each CALC cycle SHALL write the slice sum into the result register at bits 4i+3:4i, replace the latched carry with the slice carry-out, and increment i.
REQ-023 On the slice i=NIB-1, the block SHALL latch cout = slice carry-out and ovf = c3 XOR slice carry-out, and move CALC->DONE.
REQ-024 Latency SHALL be NIB edges: out_valid rises exactly NIB cycles after the acceptance edge (4 for WIDTH=16).
REQ-025 In DONE, out_valid SHALL be 1 and sum/cout/ovf SHALL be held stable until out_ready=1.
REQ-026 On an edge in DONE with out_ready=1, the block SHALL move to IDLE; in_valid SHALL be ignored on that edge, giving a throughput of one operation per NIB+2 cycles.
REQ-027 Operand inputs SHALL be ignored outside IDLE; a change on a, b or cin during CALC or DONE SHALL NOT affect the result.
REQ-028 sum, cout and ovf SHALL retain the last result while in IDLE; they are meaningful only while out_valid=1.
REQ-029 The slice index SHALL never exceed NIB-1 and SHALL NOT wrap while in CALC.

Reset
REQ-030 On any edge with rst_n=0, regardless of state (including mid-CALC and DONE), the block SHALL enter IDLE.
REQ-031 That reset edge SHALL set sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1, slice index=0 and latched carry=0, discarding any in-flight operation.
REQ-032 While rst_n=0, in_valid SHALL be ignored; the first possible acceptance SHALL be the first edge with rst_n=1.

Verification (WIDTH=16)
REQ-033 The bench SHALL cover: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0, out_valid 4 cycles after acceptance.
REQ-034 The bench SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all slices).
REQ-035 The bench SHALL cover: a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-036 The bench SHALL cover: out_ready held low 5 cycles in DONE -> out_valid=1 and sum stable throughout, in_ready=0; IDLE on the edge after out_ready=1.
REQ-037 The bench SHALL cover: rst_n=0 for one edge during the 2nd CALC cycle -> next cycle out_valid=0, busy=0, in_ready=1, sum=0; a new operation then completes correctly.
REQ-038 The bench SHALL cover: in_valid=1 continuously with out_ready=1 over 3 random operand sets -> each result matches a reference a+b+cin, with acceptances spaced 6 cycles apart.
